// File: rtl/ofifo_deskew_pkg.sv
// Shared constants for the output deskew FIFO bank and its neighbours
// (input FIFO bank, array top).
package ofifo_deskew_pkg;

    localparam int unsigned COL_DEF    = 8;
    localparam int unsigned BW_DEF     = 16;
    localparam int unsigned DEPTH_DEF  = 64;
    localparam int unsigned LANE_IDX_W = $clog2(COL_DEF);

    // Pointer width for a power-of-two lane depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Count needs one extra bit to represent the full state (count == depth).
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ofifo_deskew_if.sv
// Producer/consumer bus of the output deskew FIFO bank.
interface ofifo_deskew_if #(
    parameter int unsigned COL = 8,
    parameter int unsigned BW  = 16
);
    logic [COL*BW-1:0] in;
    logic [COL-1:0]    wr;
    logic              rd;
    logic [COL*BW-1:0] out;
    logic              o_valid;
    logic              o_full;
    logic              o_ready;
    logic              o_overflow;

    modport master (
        output in, wr, rd,
        input  out, o_valid, o_full, o_ready, o_overflow
    );

    modport slave (
        input  in, wr, rd,
        output out, o_valid, o_full, o_ready, o_overflow
    );
endinterface

// File: rtl/ofifo_deskew_lane.sv
// Single-column circular buffer with first-word-fall-through head.
// Room for a write is judged on the registered count only.
module ofifo_lane
    import ofifo_deskew_pkg::*;
#(
    parameter int unsigned BW    = BW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [BW-1:0] in,
    input  logic          wr,
    input  logic          pop,
    output logic [BW-1:0] out,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_wr_drop
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [BW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_ok, pop_ok;

    assign o_empty   = (cnt_q == '0);
    assign o_full    = (cnt_q == CNT_W'(DEPTH));
    assign wr_ok     = wr & ~o_full;
    assign pop_ok    = pop & ~o_empty;
    assign o_wr_drop = wr & o_full;
    assign out       = mem_q[rptr_q];

    // Next-state pointers and occupancy.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (wr_ok)  wptr_d = wptr_q + PTR_W'(1);
        if (pop_ok) rptr_d = rptr_q + PTR_W'(1);
        unique case ({wr_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset; with count>0 the write slot never aliases the head.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q] <= in;
    end

endmodule

// File: rtl/ofifo_deskew.sv
// Output deskew FIFO bank: independent per-column writes, atomic row pops,
// rows presented only once every column has data.
module ofifo_deskew
    import ofifo_deskew_pkg::*;
#(
    parameter int unsigned COL   = COL_DEF,
    parameter int unsigned BW    = BW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic           clk,
    input  logic           reset,
    ofifo_deskew_if.slave  bus
);

    logic [COL-1:0]    lane_empty;
    logic [COL-1:0]    lane_full;
    logic [COL-1:0]    lane_drop;
    logic [BW-1:0]     lane_out [COL];
    logic              valid_c;
    logic              pop_c;
    logic [COL*BW-1:0] out_c;
    logic              ovf_q, ovf_d;

    assign valid_c = ~|lane_empty;
    assign pop_c   = bus.rd & valid_c;

    for (genvar i = 0; i < int'(COL); i++) begin : g_lane
        ofifo_lane #(
            .BW    (BW),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .in        (bus.in[i*BW +: BW]),
            .wr        (bus.wr[i]),
            .pop       (pop_c),
            .out       (lane_out[i]),
            .o_empty   (lane_empty[i]),
            .o_full    (lane_full[i]),
            .o_wr_drop (lane_drop[i])
        );
    end

    // Aligned row, forced to zero until every lane holds a word.
    always_comb begin
        out_c = '0;
        if (valid_c) begin
            for (int i = 0; i < int'(COL); i++) begin
                out_c[i*BW +: BW] = lane_out[i];
            end
        end
    end

    assign ovf_d = ovf_q | (|lane_drop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign bus.out        = out_c;
    assign bus.o_valid    = valid_c;
    assign bus.o_full     = |lane_full;
    assign bus.o_ready    = ~|lane_full;
    assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_ofifo_deskew.sv
// Self-checking bench for ofifo_deskew against a queue-based row model.
module tb_ofifo_deskew;
    localparam int unsigned COL   = 8;
    localparam int unsigned BW    = 16;
    localparam int unsigned DEPTH = 64;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    ofifo_deskew_if #(.COL(COL), .BW(BW)) bus ();
    ofifo_deskew #(.COL(COL), .BW(BW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per column plus the sticky drop flag.
    logic [BW-1:0] mq [COL][$];
    bit            m_ovf;

    function automatic bit m_valid();
        for (int i = 0; i < int'(COL); i++) if (mq[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < int'(COL); i++) if (mq[i].size() == int'(DEPTH)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_flags();
        return {m_valid(), m_full(), ~m_full(), m_ovf};
    endfunction

    function automatic logic [COL*BW-1:0] m_out();
        logic [COL*BW-1:0] r = '0;
        if (m_valid()) for (int i = 0; i < int'(COL); i++) r[i*BW +: BW] = mq[i][0];
        return r;
    endfunction

    function automatic logic [3:0] dut_flags();
        return {bus.o_valid, bus.o_full, bus.o_ready, bus.o_overflow};
    endfunction

    function automatic logic [COL*BW-1:0] pat_row(input int base);
        logic [COL*BW-1:0] r;
        for (int i = 0; i < int'(COL); i++) r[i*BW +: BW] = BW'(base + i);
        return r;
    endfunction

    function automatic logic [COL*BW-1:0] rand_row();
        logic [COL*BW-1:0] r;
        for (int i = 0; i < int'(COL); i++) r[i*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    // One clock: drive, advance the model with pre-edge occupancy, sample at edge+1.
    task automatic cycle(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
        int  sz [COL];
        bit  pop;
        pop = r && m_valid();
        for (int i = 0; i < int'(COL); i++) sz[i] = mq[i].size();
        bus.wr = w;
        bus.in = d;
        bus.rd = r;
        @(posedge clk);
        if (pop) for (int i = 0; i < int'(COL); i++) void'(mq[i].pop_front());
        for (int i = 0; i < int'(COL); i++) begin
            if (w[i]) begin
                if (sz[i] < int'(DEPTH)) mq[i].push_back(d[i*BW +: BW]);
                else                     m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(COL); i++) mq[i].delete();
        m_ovf = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.wr = '0;
        bus.rd = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        bus.in = '0; bus.wr = '0; bus.rd = 1'b0;
        reset = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (dut_flags() !== 4'b0010) begin
            failures++; $display("FAIL reset_flags got=%b exp=%b", dut_flags(), 4'b0010);
        end
        checks++;
        if (bus.out !== '0) begin
            failures++; $display("FAIL reset_out got=%h exp=0", bus.out);
        end
    endtask

    task automatic test_skew_fill();
        logic [COL*BW-1:0] exp_row;
        for (int k = 0; k < int'(COL); k++) begin
            logic [COL*BW-1:0] d = '0;
            d[k*BW +: BW] = BW'(16'h0100 + k);
            cycle(COL'(1) << k, d, 1'b0);
            checks++;
            if (dut_flags() !== m_flags()) begin
                failures++; $display("FAIL skew_flags k=%0d got=%b exp=%b", k, dut_flags(), m_flags());
            end
        end
        exp_row = pat_row(16'h0100);
        checks++;
        if (bus.o_valid !== 1'b1 || bus.out !== exp_row) begin
            failures++; $display("FAIL skew_row got=%b/%h exp=1/%h", bus.o_valid, bus.out, exp_row);
        end
    endtask

    task automatic test_pop_drain();
        cycle('0, '0, 1'b1);
        checks++;
        if (bus.o_valid !== 1'b0 || bus.out !== '0) begin
            failures++; $display("FAIL drain got=%b/%h exp=0/0", bus.o_valid, bus.out);
        end
        cycle('0, '0, 1'b1);
        checks++;
        if (dut_flags() !== 4'b0010 || dut_flags() !== m_flags()) begin
            failures++; $display("FAIL drain_idle_rd got=%b exp=%b", dut_flags(), m_flags());
        end
        // A single write per lane must re-form a row, proving every count hit zero.
        cycle('1, pat_row(16'h0200), 1'b0);
        checks++;
        if (bus.out !== pat_row(16'h0200)) begin
            failures++; $display("FAIL drain_refill got=%h exp=%h", bus.out, pat_row(16'h0200));
        end
        cycle('0, '0, 1'b1);
    endtask

    task automatic test_full_overflow();
        logic [COL*BW-1:0] d;
        for (int v = 0; v < int'(DEPTH); v++) begin
            d = '0; d[3*BW +: BW] = BW'(v);
            cycle(8'h08, d, 1'b0);
            checks++;
            if (dut_flags() !== m_flags()) begin
                failures++; $display("FAIL fill_flags v=%0d got=%b exp=%b", v, dut_flags(), m_flags());
            end
        end
        checks++;
        if (bus.o_full !== 1'b1 || bus.o_ready !== 1'b0) begin
            failures++; $display("FAIL full_at_depth got=%b%b exp=10", bus.o_full, bus.o_ready);
        end
        d = '0; d[3*BW +: BW] = BW'(99);
        cycle(8'h08, d, 1'b0);
        checks++;
        if (bus.o_overflow !== 1'b1) begin
            failures++; $display("FAIL overflow_set got=%b exp=1", bus.o_overflow);
        end
        cycle(8'hF7, pat_row(16'h0300), 1'b0);
        checks++;
        if (bus.o_valid !== 1'b1 || bus.out[3*BW +: BW] !== BW'(0)) begin
            failures++; $display("FAIL lane3_head got=%b/%h exp=1/0", bus.o_valid, bus.out[3*BW +: BW]);
        end
        checks++;
        if (bus.out !== m_out()) begin
            failures++; $display("FAIL full_row got=%h exp=%h", bus.out, m_out());
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 6; k++) begin
            logic [COL-1:0] w;
            w = {5'b0, 1'(k < 6), 1'(k < 2), 1'(k < 4)};
            cycle(w, rand_row(), 1'b0);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (dut_flags() !== 4'b0010 || bus.out !== '0) begin
            failures++; $display("FAIL async_reset got=%b/%h exp=0010/0", dut_flags(), bus.out);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        cycle('1, pat_row(16'h0C00), 1'b0);
        checks++;
        if (bus.o_valid !== 1'b1 || bus.out !== pat_row(16'h0C00)) begin
            failures++; $display("FAIL post_reset_row got=%b/%h exp=1/%h", bus.o_valid, bus.out, pat_row(16'h0C00));
        end
    endtask

    task automatic test_wrap();
        int bad = 0;
        do_reset();
        cycle('1, pat_row(0), 1'b0);
        for (int k = 1; k <= 200; k++) begin
            cycle('1, pat_row(k * int'(COL)), 1'b1);
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_full !== 1'b0 || bus.out !== pat_row(k * int'(COL))) begin
                failures++; bad++;
                if (bad < 5) $display("FAIL wrap k=%0d got=%b/%h exp=1/%h", k, bus.o_valid, bus.out, pat_row(k * int'(COL)));
            end
        end
    endtask

    task automatic test_rd_no_row();
        do_reset();
        cycle(8'h7F, pat_row(16'h0A00), 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle('0, '0, 1'b1);
            checks++;
            if (bus.o_valid !== 1'b0 || bus.out !== '0) begin
                failures++; $display("FAIL no_row_rd k=%0d got=%b/%h exp=0/0", k, bus.o_valid, bus.out);
            end
        end
        cycle(8'h80, pat_row(16'h0A00), 1'b0);
        checks++;
        if (bus.out !== pat_row(16'h0A00)) begin
            failures++; $display("FAIL no_row_heads got=%h exp=%h", bus.out, pat_row(16'h0A00));
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int k = 0; k < 900; k++) begin
            logic [COL-1:0] w;
            int wp, rp;
            case ((k / 150) % 3)
                0:       begin wp = 85; rp = 30; end
                1:       begin wp = 40; rp = 90; end
                default: begin wp = 60; rp = 60; end
            endcase
            for (int i = 0; i < int'(COL); i++) w[i] = ($urandom_range(99) < wp);
            cycle(w, rand_row(), ($urandom_range(99) < rp));
            checks++;
            if (dut_flags() !== m_flags() || bus.out !== m_out()) begin
                failures++; bad++;
                if (bad < 5) $display("FAIL random k=%0d got=%b/%h exp=%b/%h", k, dut_flags(), bus.out, m_flags(), m_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_skew_fill();
        test_pop_drain();
        test_full_overflow();
        test_reset_mid();
        test_wrap();
        test_rd_no_row();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
